// File: rtl/add_1bit_vector_seq_if.sv
// rtl/add_1bit_vector_seq_if.sv - stimulus/response bus between sequencer and adder pair
//
// Purpose: carries one stimulus vector out to the golden adder and the
// post-route netlist, and carries both of their outputs back.
// Signals:
//   a, b       stimulus operands (sequencer -> adders)
//   vec_valid  a/b hold a live vector (sequencer -> adders)
//   c_golden   golden adder output (adders -> sequencer)
//   c_netlist  post-route netlist output (adders -> sequencer)
// Modports: master = sequencer side, slave = adder-pair side.

interface add_1bit_vector_seq_if;
  logic a;
  logic b;
  logic vec_valid;
  logic c_golden;
  logic c_netlist;

  modport master (
    output a,
    output b,
    output vec_valid,
    input  c_golden,
    input  c_netlist
  );

  modport slave (
    input  a,
    input  b,
    input  vec_valid,
    output c_golden,
    output c_netlist
  );
endinterface

// File: rtl/add_1bit_vector_seq.sv
// rtl/add_1bit_vector_seq.sv - 1-bit adder regression sequencer and result checker
//
// Purpose: drives a/b into the golden adder and the post-route netlist, compares
// their outputs once per vector, accumulates saturating counts and a verdict.
// Optional feature macro: ADD1_SEQ_DIRECTED_EN (adds directed vectors 00,10,01,11
// ahead of the pseudo-random phase).
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   start           begin a run (sampled in IDLE/DONE only)
//   vec_if          master side of the stimulus/response bus
//   busy, done      run in progress / run complete (held until start or reset)
//   pass            done with zero mismatches
//   vec_cnt         vectors compared (saturating)
//   mismatch_cnt    failed compares (saturating)
//   first_fail_idx  index of first failing vector, all-ones if none

module add_1bit_vector_seq #(
  parameter int          NUM_RANDOM    = 500,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int          CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  add_1bit_vector_seq_if.master vec_if,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     vec_cnt,
  output logic [CNT_W-1:0]     mismatch_cnt,
  output logic [CNT_W-1:0]     first_fail_idx
);

`ifdef ADD1_SEQ_DIRECTED_EN
  localparam int NUM_DIRECTED = 4;
`else
  localparam int NUM_DIRECTED = 0;
`endif
  localparam int NUM_VEC = NUM_DIRECTED + NUM_RANDOM;
  // The vector index is kept wide enough for the whole run independently of
  // CNT_W, so a narrow counter build still knows when the run ends.
  localparam int               IDX_W       = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VEC - 1);
  localparam logic [15:0]      SEED        = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             a_q, a_d, b_q, b_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       settle_q, settle_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] mm_cnt_q, mm_cnt_d;
  logic [CNT_W-1:0] ffi_q, ffi_d;

  logic             mismatch;
  logic             do_load;
  logic [IDX_W-1:0] load_idx;
  logic [15:0]      load_lfsr;

  // Galois right-shift step, feedback mask B400 applied when bit 0 falls out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    lfsr_d    = lfsr_q;
    idx_d     = idx_q;
    settle_d  = settle_q;
    vec_cnt_d = vec_cnt_q;
    mm_cnt_d  = mm_cnt_q;
    ffi_d     = ffi_q;
    // Case inequality so an X/Z from either adder is reported as a failure.
    mismatch  = (vec_if.c_golden !== vec_if.c_netlist);
    do_load   = 1'b0;
    load_idx  = idx_q + IDX_W'(1);
    load_lfsr = lfsr_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_SETTLE;
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          vec_cnt_d = '0;
          mm_cnt_d  = '0;
          ffi_d     = '1;
          do_load   = 1'b1;
          load_idx  = '0;
          load_lfsr = SEED;
        end
      end
      S_SETTLE: begin
        if (settle_q == 4'd0) begin
          state_d = S_CHECK;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      S_CHECK: begin
        if (vec_cnt_q != '1) begin
          vec_cnt_d = vec_cnt_q + CNT_W'(1);
        end
        if (mismatch) begin
          if (mm_cnt_q != '1) begin
            mm_cnt_d = mm_cnt_q + CNT_W'(1);
          end
          // mismatch_cnt saturates and never returns to zero, so zero means
          // this is the first failure of the run.
          if (mm_cnt_q == '0) begin
            ffi_d = CNT_W'(idx_q);
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (mm_cnt_d == '0);
        end else begin
          state_d = S_SETTLE;
          do_load = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_load) begin
      settle_d = SETTLE_LOAD;
      idx_d    = load_idx;
      lfsr_d   = load_lfsr;
`ifdef ADD1_SEQ_DIRECTED_EN
      if (int'(load_idx) < NUM_DIRECTED) begin
        a_d = load_idx[0];
        b_d = load_idx[1];
      end else begin
        a_d    = load_lfsr[0];
        b_d    = load_lfsr[1];
        lfsr_d = lfsr_step(load_lfsr);
      end
`else
      a_d    = load_lfsr[0];
      b_d    = load_lfsr[1];
      lfsr_d = lfsr_step(load_lfsr);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      lfsr_q    <= SEED;
      idx_q     <= '0;
      settle_q  <= 4'd0;
      vec_cnt_q <= '0;
      mm_cnt_q  <= '0;
      ffi_q     <= '1;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      lfsr_q    <= lfsr_d;
      idx_q     <= idx_d;
      settle_q  <= settle_d;
      vec_cnt_q <= vec_cnt_d;
      mm_cnt_q  <= mm_cnt_d;
      ffi_q     <= ffi_d;
    end
  end

  assign vec_if.a         = a_q;
  assign vec_if.b         = b_q;
  assign vec_if.vec_valid = valid_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign vec_cnt          = vec_cnt_q;
  assign mismatch_cnt     = mm_cnt_q;
  assign first_fail_idx   = ffi_q;

endmodule

// File: doc/add_1bit_vector_seq.md
# add_1bit_vector_seq

Synthesizable stimulus sequencer and result checker for the 1-bit adder post-route regression. Drives `a`/`b` into the golden adder and the post-route fabric netlist in parallel, then compares their `c` outputs once per vector. Accumulates vector and mismatch counts and raises a pass/fail verdict, so the check can run on hardware as well as in simulation. Sits directly upstream of the adder pair and consumes both of their outputs.

## Interface
- `NUM_RANDOM`, 500: number of pseudo-random vectors after the directed phase.
- `SETTLE_CYCLES`, 1: cycles between vector load and compare; legal range 1–15.
- `LFSR_SEED`, 16'hACE1: LFSR load value; a value of 0 is replaced by 16'h0001.
- `CNT_W`, 16: width of all counters and indices.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a run; sampled in IDLE or DONE only.
- `c_golden` in 1: golden adder output.
- `c_netlist` in 1: post-route netlist output.
- `a` out 1: stimulus operand a (registered).
- `b` out 1: stimulus operand b (registered).
- `vec_valid` out 1: a/b hold a live vector.
- `busy` out 1: run in progress.
- `done` out 1: run complete; held until the next start or reset.
- `pass` out 1: `done` && `mismatch_cnt`==0.
- `vec_cnt` out CNT_W: vectors compared; saturating.
- `mismatch_cnt` out CNT_W: failed compares; saturating.
- `first_fail_idx` out CNT_W: index of the first failing vector; all-ones if none.

## Operation
- States and transitions:
  - IDLE → SETTLE on `start`.
  - SETTLE → CHECK after SETTLE_CYCLES cycles.
  - CHECK → SETTLE if vectors remain, otherwise CHECK → DONE.
  - DONE → SETTLE on `start`.
- Start edge (IDLE or DONE with `start`=1):
  - Clear all counters; set `first_fail_idx` to all-ones.
  - Reload the LFSR.
  - Load vector 0; set `vec_valid`=1, `busy`=1, `done`=0.
- Vector order:
  - Directed phase: 00, 10, 01, 11 as (a,b).
  - Random phase: NUM_RANDOM vectors with a=lfsr[0], b=lfsr[1] of the current LFSR state. The LFSR advances once per random vector loaded.
- LFSR: 16-bit Galois, right shift. When the shifted-out bit is 1, XOR with 16'hB400.
- CHECK edge:
  - Mismatch when `c_golden`≠`c_netlist`. In simulation, X/Z on either input also counts as a mismatch (case-inequality semantics).
  - `vec_cnt`++. On mismatch, `mismatch_cnt`++. Both saturate at all-ones.
  - On the first mismatch of a run, `first_fail_idx` ← the current vector index.
  - Same edge: load the next vector, or enter DONE with `vec_valid`=0 and a/b holding their last values.
- `start` while busy: ignored.
- Reset (any state, including mid-run) forces on that edge:
  - IDLE
  - a=b=0, `vec_valid`=0, `busy`=0, `done`=0, `pass`=0
  - `vec_cnt`=0, `mismatch_cnt`=0, `first_fail_idx`=all-ones
  - LFSR=seed

## Timing
- Vector period: SETTLE_CYCLES+1 cycles; 2 cycles at the default.
- Compare latency: the vector loaded at edge k is compared at edge k+SETTLE_CYCLES+1.
- Vector and counter loads happen at that same edge. The DUTs see the new a/b for SETTLE_CYCLES+1 full cycles before sampling.
- Run length: N×(SETTLE_CYCLES+1) cycles from the start edge to `done`=1, where N = total vectors.
- `pass` and `done` rise in the same cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `ADD1_SEQ_DIRECTED_EN` defined:
  - The four directed vectors precede the random phase.
  - N = 4+NUM_RANDOM.
  - The first random vector has index 4.
- `ADD1_SEQ_DIRECTED_EN` undefined:
  - No directed phase; vector 0 is the first LFSR vector.
  - N = NUM_RANDOM.

## Test plan
- Clean run: macro on, NUM_RANDOM=8, SETTLE_CYCLES=1, `c_netlist` tied to `c_golden`, pulse `start` → `done`=`pass`=1 exactly 24 cycles after the start edge; `vec_cnt`=12, `mismatch_cnt`=0, `first_fail_idx`=16'hFFFF.
- Sequence check: seed ACE1, macro on → (a,b) per vector = 00, 10, 01, 11, then 10 (LFSR ACE1), then 00 (LFSR E270); each held 2 cycles.
- Single fault: invert `c_netlist` during vector 2's CHECK only → `mismatch_cnt`=1, `first_fail_idx`=2, `pass`=0 at done.
- Reset mid-run: assert `rst` for one cycle during vector 5 → next cycle all outputs at reset values; restart reproduces the identical a/b sequence from vector 0.
- Start handling: hold `start`=1 throughout the run → no restart while busy; restart occurs on the first DONE cycle. Counters clear and `done` drops on the next edge.
- Saturation: CNT_W=2, macro off, NUM_RANDOM=8, `c_netlist`=~`c_golden` → `vec_cnt`=3, `mismatch_cnt`=3, `first_fail_idx`=0, `done` after 16 cycles.
